// File: rtl/sensor_packet_reader.sv
// Reads one 16-byte sensor packet over SPI mode 0 after a load/done handshake,
// validates the header and latches the decoded quaternion and gyro fields.
module sensor_packet_reader #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned TIMEOUT_CYC = 30000
) (
    input  logic               clk,
    input  logic               fpga_rst_n,
    input  logic               start,
    output logic               load,
    input  logic               done,
    output logic               sck,
    output logic               mosi,
    input  logic               miso,
    output logic               busy,
    output logic               pkt_valid,
    output logic signed [15:0] quat_w,
    output logic signed [15:0] quat_x,
    output logic signed [15:0] quat_y,
    output logic signed [15:0] quat_z,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               quat_ok,
    output logic               gyro_ok,
    output logic               hdr_err,
    output logic               timeout_err
);

    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PKT_BITS = 128;
    localparam int unsigned BIT_W    = 7;
    localparam int unsigned GAP_CYC  = 4;
    localparam int unsigned GAP_W    = 2;
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SHIFT,
        S_CHECK,
        S_GAP
    } state_t;

    state_t               state;
    logic [1:0]           rst_pipe;
    logic                 run;
    logic                 done_meta;
    logic                 done_s;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [PKT_BITS-1:0]  shreg;

    assign mosi = 1'b0;
    assign run  = rst_pipe[1];

    // Reset asserts asynchronously but the FSM only runs two edges after release
    always_ff @(posedge clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    // done comes from another clock domain
    always_ff @(posedge clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
        end else begin
            done_meta <= done;
            done_s    <= done_meta;
        end
    end

    always_ff @(posedge clk or negedge fpga_rst_n) begin
        if (!fpga_rst_n) begin
            state       <= S_IDLE;
            load        <= 1'b0;
            sck         <= 1'b0;
            busy        <= 1'b0;
            pkt_valid   <= 1'b0;
            tmo_cnt     <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            shreg       <= '0;
            quat_w      <= '0;
            quat_x      <= '0;
            quat_y      <= '0;
            quat_z      <= '0;
            gyro_x      <= '0;
            gyro_y      <= '0;
            gyro_z      <= '0;
            quat_ok     <= 1'b0;
            gyro_ok     <= 1'b0;
            hdr_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            if (run) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_REQ;
                            load    <= 1'b1;
                            busy    <= 1'b1;
                            tmo_cnt <= '0;
                        end
                    end
                    S_REQ: begin
                        if (done_s) begin
                            state   <= S_SHIFT;
                            sck     <= 1'b0;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                        end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                            state       <= S_IDLE;
                            load        <= 1'b0;
                            busy        <= 1'b0;
                            timeout_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    // Low half then high half; sample on the rising toggle, count on the falling one
                    S_SHIFT: begin
                        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                            div_cnt <= '0;
                            sck     <= ~sck;
                            if (!sck) begin
                                shreg <= {shreg[PKT_BITS-2:0], miso};
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                if (bit_cnt == BIT_W'(PKT_BITS - 1)) begin
                                    state <= S_CHECK;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    S_CHECK: begin
                        state   <= S_GAP;
                        load    <= 1'b0;
                        gap_cnt <= '0;
                        if (shreg[127:120] == HDR_BYTE) begin
                            quat_ok     <= shreg[112];
                            gyro_ok     <= shreg[113];
                            quat_w      <= shreg[111:96];
                            quat_x      <= shreg[95:80];
                            quat_y      <= shreg[79:64];
                            quat_z      <= shreg[63:48];
                            gyro_x      <= shreg[47:32];
                            gyro_y      <= shreg[31:16];
                            gyro_z      <= shreg[15:0];
                            pkt_valid   <= 1'b1;
                            hdr_err     <= 1'b0;
                            timeout_err <= 1'b0;
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        load  <= 1'b0;
                        sck   <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sensor_packet_reader.sv
// Randomized bench for sensor_packet_reader: a byte-level SPI slave model and
// a field-level expectation model for the latched outputs and sticky flags.
module tb_sensor_packet_reader;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned TMO     = 300;
    localparam int          CLK_NS  = 10;

    logic               clk = 1'b0;
    logic               fpga_rst_n;
    logic               start;
    logic               load;
    logic               done;
    logic               sck;
    logic               mosi;
    logic               miso;
    logic               busy;
    logic               pkt_valid;
    logic signed [15:0] quat_w, quat_x, quat_y, quat_z, gyro_x, gyro_y, gyro_z;
    logic               quat_ok, gyro_ok, hdr_err, timeout_err;

    sensor_packet_reader #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .fpga_rst_n(fpga_rst_n), .start(start), .load(load), .done(done),
        .sck(sck), .mosi(mosi), .miso(miso), .busy(busy), .pkt_valid(pkt_valid),
        .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .quat_ok(quat_ok), .gyro_ok(gyro_ok), .hdr_err(hdr_err), .timeout_err(timeout_err)
    );

    always #(CLK_NS/2) clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]         pb [16];
    logic signed [15:0] exp_f [7];
    logic               exp_qok, exp_gok, exp_hdr, exp_tmo;

    int  sck_rises  = 0;
    int  period_bad = 0;
    bit  have_prev  = 0;
    time prev_rise  = 0;
    int  bit_idx    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Slave: first bit presented when load rises, next bit after each falling SCK
    always @(posedge load) begin
        bit_idx = 0;
        miso    = pb[0][7];
    end
    always @(negedge sck) begin
        if (load && bit_idx < 127) begin
            bit_idx++;
            miso = pb[bit_idx/8][7 - (bit_idx % 8)];
        end
    end

    always @(posedge sck) begin
        sck_rises++;
        if (have_prev && ($time - prev_rise) != time'(2 * CLK_DIV * CLK_NS)) period_bad++;
        prev_rise = $time;
        have_prev = 1'b1;
    end

    task automatic model_reset();
        for (int k = 0; k < 7; k++) exp_f[k] = '0;
        exp_qok = 1'b0; exp_gok = 1'b0; exp_hdr = 1'b0; exp_tmo = 1'b0;
    endtask

    task automatic model_packet();
        if (pb[0] == 8'hA5) begin
            for (int k = 0; k < 7; k++) exp_f[k] = {pb[2+2*k], pb[3+2*k]};
            exp_qok = pb[1][0];
            exp_gok = pb[1][1];
            exp_hdr = 1'b0;
            exp_tmo = 1'b0;
        end else begin
            exp_hdr = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_quat_w"}, 32'(quat_w), 32'(exp_f[0]));
        check_val({tag, "_quat_x"}, 32'(quat_x), 32'(exp_f[1]));
        check_val({tag, "_quat_y"}, 32'(quat_y), 32'(exp_f[2]));
        check_val({tag, "_quat_z"}, 32'(quat_z), 32'(exp_f[3]));
        check_val({tag, "_gyro_x"}, 32'(gyro_x), 32'(exp_f[4]));
        check_val({tag, "_gyro_y"}, 32'(gyro_y), 32'(exp_f[5]));
        check_val({tag, "_gyro_z"}, 32'(gyro_z), 32'(exp_f[6]));
        check_val({tag, "_quat_ok"}, 32'(quat_ok), 32'(exp_qok));
        check_val({tag, "_gyro_ok"}, 32'(gyro_ok), 32'(exp_gok));
        check_val({tag, "_hdr_err"}, 32'(hdr_err), 32'(exp_hdr));
        check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'(exp_tmo));
    endtask

    task automatic random_packet(input bit good);
        for (int i = 0; i < 16; i++) pb[i] = 8'($urandom);
        if (good) pb[0] = 8'hA5;
        else if (pb[0] == 8'hA5) pb[0] = 8'h5A;
    endtask

    task automatic pulse_start_wait_load(input string tag);
        int t;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t = 0;
        while (!load && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_load_rise"}, 32'(load), 32'd1);
    endtask

    // stray: 0 none, 1 start pulse mid-transfer, 2 start pulse in the last GAP cycle
    task automatic do_read(input string tag, input int stray);
        int  t, drop_at, pv_cnt, pv_at;
        bit  good;
        good       = (pb[0] == 8'hA5);
        sck_rises  = 0;
        period_bad = 0;
        have_prev  = 1'b0;
        pulse_start_wait_load(tag);
        repeat ($urandom_range(0, 15)) @(negedge clk);
        done    = 1'b1;
        drop_at = $urandom_range(10, 300);
        pv_cnt  = 0;
        pv_at   = -1;
        t       = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
            if (t == drop_at) done = 1'b0;
            if (pkt_valid) begin
                pv_cnt++;
                pv_at = t;
            end
            start = (stray == 1 && t == 100) || (stray == 2 && pv_at >= 0 && t == pv_at + 3);
        end
        start = 1'b0;
        done  = 1'b0;
        check_val({tag, "_done_in_budget"}, 32'(t < 3000), 32'd1);
        check_val({tag, "_pkt_valid_pulses"}, 32'(pv_cnt), good ? 32'd1 : 32'd0);
        check_val({tag, "_sck_rises"}, 32'(sck_rises), 32'd128);
        check_val({tag, "_sck_period_bad"}, 32'(period_bad), 32'd0);
        check_val({tag, "_sck_idle"}, 32'(sck), 32'd0);
        model_packet();
        repeat (3) @(negedge clk);
        check_val({tag, "_stay_idle_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_stay_idle_load"}, 32'(load), 32'd0);
        check_val({tag, "_mosi"}, 32'(mosi), 32'd0);
        check_outputs(tag);
    endtask

    task automatic do_timeout(input string tag);
        int t;
        pulse_start_wait_load(tag);
        t = 0;
        while (load && t < int'(TMO) + 50) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_load_high_cycles"}, 32'(t), 32'(TMO));
        check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
        exp_tmo = 1'b1;
        check_outputs(tag);
    endtask

    task automatic do_reset_mid(input string tag);
        int t;
        random_packet(1'b1);
        sck_rises = 0;
        have_prev = 1'b0;
        pulse_start_wait_load(tag);
        done = 1'b1;
        t = 0;
        while (sck_rises < 60 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_reached_bit60"}, 32'(sck_rises >= 60), 32'd1);
        fpga_rst_n = 1'b0;
        #1;
        done = 1'b0;
        model_reset();
        check_val({tag, "_load"}, 32'(load), 32'd0);
        check_val({tag, "_sck"}, 32'(sck), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
        check_outputs(tag);
        repeat (3) @(negedge clk);
        fpga_rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        fpga_rst_n = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        miso       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_load", 32'(load), 32'd0);
        check_val("rst_sck", 32'(sck), 32'd0);
        check_val("rst_mosi", 32'(mosi), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_outputs("rst");
        fpga_rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_reset_mid("rst_mid");
        random_packet(1'b1);
        do_read("after_rst", 0);

        pb = '{8'hA5, 8'h03, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h00,
               8'hFF, 8'hFE, 8'h00, 8'h10, 8'hFF, 8'hF0, 8'h12, 8'h34};
        do_read("good", 0);
        check_val("good_qw_const", 32'($unsigned(quat_w)), 32'h7FFF);
        check_val("good_qy_const", 32'($unsigned(quat_y)), 32'h8000);
        check_val("good_gy_const", 32'($unsigned(gyro_y)), 32'hFFF0);
        check_val("good_gz_const", 32'($unsigned(gyro_z)), 32'h1234);

        random_packet(1'b0);
        pb[0] = 8'h5A;
        do_read("bad_hdr", 0);
        random_packet(1'b1);
        do_read("clear_hdr", 0);

        do_timeout("timeout");
        random_packet(1'b0);
        do_read("bad_after_tmo", 0);
        random_packet(1'b1);
        do_read("clear_both", 0);

        random_packet(1'b1);
        do_read("start_mid", 1);
        random_packet(1'b1);
        do_read("start_gap_exit", 2);
        random_packet(1'b1);
        do_read("next_after_gap", 0);

        for (int i = 0; i < 12; i++) begin
            random_packet($urandom_range(0, 3) != 0);
            do_read($sformatf("rand%0d", i), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
